// File: rtl/alu_arbiter.sv
// ============================================================================
//  Module   : alu_arbiter
//  Purpose  : Shares one combinational ALU between two requesters using
//             valid/ready request and response handshakes.
//  Option   : ALU_ARB_FIXED_PRIO_EN selects fixed priority (r0 wins ties);
//             when it is undefined, ties are resolved round-robin.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_arbiter #(
  parameter int nIO = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           r0_valid,
  input  logic           r1_valid,
  output logic           r0_ready,
  output logic           r1_ready,
  input  logic [2:0]     r0_op,
  input  logic [2:0]     r1_op,
  input  logic [nIO-1:0] r0_a,
  input  logic [nIO-1:0] r1_a,
  input  logic [nIO-1:0] r0_b,
  input  logic [nIO-1:0] r1_b,
  output logic           r0_rvalid,
  output logic           r1_rvalid,
  input  logic           r0_rready,
  input  logic           r1_rready,
  output logic [nIO-1:0] resp_z,
  output logic           resp_ov,
  output logic [nIO-1:0] alu_a,
  output logic [nIO-1:0] alu_b,
  output logic [2:0]     alu_op,
  input  logic [nIO-1:0] alu_z,
  input  logic           alu_ov
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           gnt_q, gnt_d;
  logic [2:0]     op_q, op_d;
  logic [nIO-1:0] a_q, a_d;
  logic [nIO-1:0] b_q, b_d;
  logic [nIO-1:0] z_q, z_d;
  logic           ov_q, ov_d;

  logic           w_any;
  logic           w_pick;   // 1 selects r1, 0 selects r0
  logic           w_accept;
  logic           w_rready;

  assign w_any    = r0_valid | r1_valid;
  assign w_accept = (state_q == S_IDLE) && w_any;
  assign w_rready = gnt_q ? r1_rready : r0_rready;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign w_pick = ~r0_valid & r1_valid;
`else
  logic last_q, last_d;

  // A tie goes to whichever requester was not granted most recently.
  assign w_pick = r1_valid & (~r0_valid | ~last_q);
  assign last_d = w_accept ? w_pick : last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      z_q     <= z_d;
      ov_q    <= ov_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    z_d       = z_q;
    ov_d      = ov_q;
    r0_ready  = 1'b0;
    r1_ready  = 1'b0;
    r0_rvalid = 1'b0;
    r1_rvalid = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          r0_ready = ~w_pick;
          r1_ready = w_pick;
          gnt_d    = w_pick;
          op_d     = w_pick ? r1_op : r0_op;
          a_d      = w_pick ? r1_a  : r0_a;
          b_d      = w_pick ? r1_b  : r0_b;
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        z_d     = alu_z;
        ov_d    = alu_ov;
        state_d = S_RESP;
      end
      S_RESP: begin
        r0_rvalid = ~gnt_q;
        r1_rvalid = gnt_q;
        if (w_rready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The ALU always sees the operand register, even while idle.
  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign alu_op  = op_q;
  assign resp_z  = z_q;
  assign resp_ov = ov_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
//  Module   : tb_alu_arbiter
//  Purpose  : Directed and randomized bench for alu_arbiter against a
//             transaction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v   [2];
  logic [2:0] op  [2];
  logic [7:0] a   [2];
  logic [7:0] b   [2];
  logic       rr  [2];

  logic       r0_ready, r1_ready, r0_rvalid, r1_rvalid, resp_ov, alu_ov;
  logic [7:0] resp_z, alu_a, alu_b, alu_z;
  logic [2:0] alu_op;

  int errors = 0;
  int checks = 0;

  // Model of the shared ALU: add for every op, signed overflow flag.
  assign alu_z  = alu_a + alu_b;
  assign alu_ov = (alu_a[7] == alu_b[7]) && (alu_z[7] != alu_a[7]);

  always #5 clk = ~clk;

  alu_arbiter #(.nIO(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .r0_valid (v[0]),
    .r1_valid (v[1]),
    .r0_ready (r0_ready),
    .r1_ready (r1_ready),
    .r0_op    (op[0]),
    .r1_op    (op[1]),
    .r0_a     (a[0]),
    .r1_a     (a[1]),
    .r0_b     (b[0]),
    .r1_b     (b[1]),
    .r0_rvalid(r0_rvalid),
    .r1_rvalid(r1_rvalid),
    .r0_rready(rr[0]),
    .r1_rready(rr[1]),
    .resp_z   (resp_z),
    .resp_ov  (resp_ov),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_z    (alu_z),
    .alu_ov   (alu_ov)
  );

  // Reference model: one outstanding transaction at a time.
  bit         busy = 0;
  int         age = 0;
  int         cur_id = 0;
  int         last_win = 1;
  logic [7:0] cur_a = 0, cur_b = 0, cur_z = 0, m_rz = 0;
  logic [2:0] cur_op = 0;
  bit         cur_ov = 0, m_rov = 0;
  bit         acc [2];
  int         gnt_log[$];

  function automatic logic [7:0] ref_z(input logic [7:0] x, input logic [7:0] y);
    int s;
    s = int'(x) + int'(y);
    return s[7:0];
  endfunction

  function automatic bit ref_ov(input logic [7:0] x, input logic [7:0] y);
    int s;
    s = int'($signed(x)) + int'($signed(y));
    return (s > 127) || (s < -128);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Check outputs at the falling edge, advance the model, step one cycle.
  task automatic tick();
    int win;
    bit any;
    #1;
    any = v[0] | v[1];
    if (v[0] && v[1]) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      win = 0;
`else
      win = (last_win == 1) ? 0 : 1;
`endif
    end else begin
      win = v[0] ? 0 : 1;
    end
    chk("r0_ready",  r0_ready,  !busy && any && win == 0);
    chk("r1_ready",  r1_ready,  !busy && any && win == 1);
    chk("r0_rvalid", r0_rvalid, busy && age >= 1 && cur_id == 0);
    chk("r1_rvalid", r1_rvalid, busy && age >= 1 && cur_id == 1);
    chk("resp_z",    resp_z,    m_rz);
    chk("resp_ov",   resp_ov,   m_rov);
    chk("alu_a",     alu_a,     cur_a);
    chk("alu_b",     alu_b,     cur_b);
    chk("alu_op",    alu_op,    cur_op);
    acc[0] = 0;
    acc[1] = 0;
    if (rst) begin
      busy = 0; last_win = 1;
      cur_a = 0; cur_b = 0; cur_op = 0; cur_z = 0; cur_ov = 0;
      m_rz = 0; m_rov = 0;
    end else if (!busy) begin
      if (any) begin
        busy = 1; age = 0; cur_id = win; last_win = win;
        cur_a = a[win]; cur_b = b[win]; cur_op = op[win];
        cur_z = ref_z(a[win], b[win]);
        cur_ov = ref_ov(a[win], b[win]);
        acc[win] = 1;
        gnt_log.push_back(win);
      end
    end else if (age == 0) begin
      m_rz = cur_z; m_rov = cur_ov; age = 1;
    end else if (rr[cur_id]) begin
      busy = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(input int id, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    v[id] = 1'b1; op[id] = o; a[id] = x; b[id] = y;
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (!busy && !v[0] && !v[1]) break;
      rr[0] = 1'b1; rr[1] = 1'b1;
      tick();
      if (acc[0]) v[0] = 1'b0;
      if (acc[1]) v[1] = 1'b0;
    end
    chk("drain_timeout", busy, 0);
  endtask

  initial begin
    int ncont;
    for (int i = 0; i < 2; i++) begin
      v[i] = 0; op[i] = 0; a[i] = 0; b[i] = 0; rr[i] = 0; acc[i] = 0;
    end
    @(negedge clk);

    // Reset held for two cycles.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_resp_z", resp_z, 8'd0);
    chk("rst_alu_a", alu_a, 8'd0);
    chk("rst_r0_ready", r0_ready, 1'b0);
    chk("rst_r1_rvalid", r1_rvalid, 1'b0);

    // Single r0 request 5+3.
    rr[0] = 1'b1;
    load(0, 3'b000, 8'd5, 8'd3);
    tick();
    v[0] = 1'b0;
    #1;
    chk("single_exec_rvalid", r0_rvalid, 1'b0);
    tick();
    #1;
    chk("single_rvalid", r0_rvalid, 1'b1);
    chk("single_z", resp_z, 8'd8);
    chk("single_ov", resp_ov, 1'b0);
    chk("single_r1_rvalid", r1_rvalid, 1'b0);
    tick();

    // r1 overflow with a four-cycle response stall; r0 waits meanwhile.
    rr[1] = 1'b0;
    load(1, 3'b001, 8'd100, 8'd50);
    tick();
    v[1] = 1'b0;
    load(0, 3'b010, 8'd1, 8'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall_rvalid", r1_rvalid, 1'b1);
      chk("stall_z", resp_z, 8'h96);
      chk("stall_ov", resp_ov, 1'b1);
      chk("stall_r0_ready", r0_ready, 1'b0);
      tick();
    end
    v[0] = 1'b0;
    rr[1] = 1'b1;
    tick();

    // Contention: both valid every cycle for four operations.
    gnt_log.delete();
    ncont = 0;
    load(0, 3'b011, 8'd10, 8'd20);
    load(1, 3'b100, 8'd30, 8'd40);
    for (int i = 0; i < 40 && ncont < 4; i++) begin
      tick();
      for (int x = 0; x < 2; x++) begin
        if (acc[x]) begin
          ncont++;
          a[x] = a[x] + 8'd7;
          b[x] = b[x] + 8'd3;
        end
      end
    end
    v[0] = 1'b0;
    v[1] = 1'b0;
    drain();
    chk("cont_count", gnt_log.size(), 4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      chk("cont_order", gnt_log[i], 0);
`else
      chk("cont_order", gnt_log[i], i % 2);
`endif
    end

    // Reset while a response is pending, then a normal r0 operation.
    rr[0] = 1'b0;
    load(0, 3'b000, 8'd9, 8'd9);
    tick();
    v[0] = 1'b0;
    tick();
    #1;
    chk("midrst_pre_rvalid", r0_rvalid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_rvalid", r0_rvalid, 1'b0);
    chk("midrst_resp_z", resp_z, 8'd0);
    rr[0] = 1'b1;
    load(0, 3'b000, 8'hEC, 8'd7);
    tick();
    v[0] = 1'b0;
    tick();
    #1;
    chk("midrst_after_z", resp_z, 8'hF3);
    tick();

    // Non-granted rready must not complete r0's response.
    rr[0] = 1'b0;
    rr[1] = 1'b1;
    load(0, 3'b101, 8'd64, 8'd64);
    tick();
    v[0] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #1;
    chk("wrong_rready_hold", r0_rvalid, 1'b1);
    chk("wrong_rready_ov", resp_ov, 1'b1);
    rr[0] = 1'b1;
    tick();
    #1;
    chk("wrong_rready_done", r0_rvalid, 1'b0);

    // Randomized traffic checked by the model every cycle.
    for (int n = 0; n < 400; n++) begin
      for (int x = 0; x < 2; x++) begin
        if (acc[x] || !v[x]) begin
          v[x] = ($urandom_range(0, 2) != 0);
          op[x] = 3'($urandom_range(0, 7));
          a[x] = 8'($urandom_range(0, 255));
          b[x] = 8'($urandom_range(0, 255));
        end
        rr[x] = ($urandom_range(0, 3) != 0);
      end
      tick();
    end
    v[0] = 1'b0;
    v[1] = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
